multicycle_control: RTL and testbench

//  Multi-cycle control sequencer for the custom CPU. It replaces single-cycle opcode decoding with a

---
 rtl/cpu_ctrl_pkg.sv | 17 +
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_control.sv | 167 ++++++++++++++++
 tb/tb_multicycle_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and opcode class-bit positions for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam int OP_ALU_BIT = 3;
  localparam int OP_BR_BIT  = 2;
  localparam int OP_ST_BIT  = 1;
  localparam int OP_LD_BIT  = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: prioritised class flags plus the ALU-side datapath selects.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2
) (
  input  logic [OPCODE_W-1:0] op,
  output logic                is_br,
  output logic                is_ld,
  output logic                is_st,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                reg2loc
);

  // Branch wins over load, load over store; anything else non-zero runs as a plain ALU op.
  always_comb begin
    is_br   = op[OP_BR_BIT];
    is_ld   = op[OP_LD_BIT] & ~op[OP_BR_BIT];
    is_st   = op[OP_ST_BIT] & ~op[OP_BR_BIT] & ~op[OP_LD_BIT];
    alu_op  = op[OPCODE_W-1 -: ALUOP_W];
    alu_src = is_ld | is_st;
    reg2loc = is_br | is_st;
  end

endmodule

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB control sequencer sharing one memory port with a ready handshake.
// Define MC_CTRL_PERF_EN to add the cyc_cnt / ret_cnt performance counter ports.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 4,
  parameter int ALUOP_W    = 2
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  alu_zero,
  input  logic                  mem_ready,
  output logic [2:0]            state_o,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic [ALUOP_W-1:0]    alu_op,
  output logic                  alu_src,
  output logic                  reg2loc,
  output logic                  reg_we,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_to_reg,
`ifdef MC_CTRL_PERF_EN
  output logic [PERF_CNT_W-1:0] cyc_cnt,
  output logic [PERF_CNT_W-1:0] ret_cnt,
`endif
  output logic                  instr_done
);

  state_e                state_q, state_d;
  logic [OPCODE_W-1:0]   op_q, op_d;
  logic                  is_br, is_ld, is_st;
  logic [ALUOP_W-1:0]    dec_alu_op;
  logic                  dec_alu_src, dec_reg2loc;

  ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .op      (op_q),
    .is_br   (is_br),
    .is_ld   (is_ld),
    .is_st   (is_st),
    .alu_op  (dec_alu_op),
    .alu_src (dec_alu_src),
    .reg2loc (dec_reg2loc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Everything is gated by rst_n so that run cannot leak onto mem_req while reset is held.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    state_o    = 3'd0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    alu_op     = '0;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    reg_we     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      state_o = state_q;
      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        reg2loc = dec_reg2loc;
      end
      case (state_q)
        FETCH: begin
          mem_req = run;
          if (run && mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          op_d = opcode;
          if (opcode == '0) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          if (is_br) begin
            pc_src     = 1'b1;
            pc_we      = alu_zero;
            instr_done = 1'b1;
            state_d    = FETCH;
          end else if (is_ld || is_st) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = is_st;
          if (mem_ready) begin
            if (is_ld) begin
              state_d = WB;
            end else begin
              instr_done = 1'b1;
              state_d    = FETCH;
            end
          end
        end
        WB: begin
          reg_we     = 1'b1;
          mem_to_reg = is_ld;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [PERF_CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ret_cnt_d = ret_cnt_q;
    if (run || state_q != FETCH) cyc_cnt_d = cyc_cnt_q + 1'b1;
    if (instr_done)              ret_cnt_d = ret_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected per-cycle output vectors are queued, then
// popped and compared at the falling edge. Perf counter checks are added under MC_CTRL_PERF_EN.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic [2:0] state_o;
  logic       ir_we, pc_we, pc_src, alu_src, reg2loc, reg_we;
  logic       mem_req, mem_we, mem_to_reg, instr_done;
  logic [1:0] alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
  logic [31:0] exp_cyc, exp_ret;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .state_o    (state_o),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg2loc    (reg2loc),
    .reg_we     (reg_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_to_reg (mem_to_reg),
`ifdef MC_CTRL_PERF_EN
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt),
`endif
    .instr_done (instr_done)
  );

  // {state, ir_we, pc_we, pc_src, alu_op, alu_src, reg2loc, reg_we, mem_req, mem_we, mem_to_reg, instr_done}
  logic [14:0] obs;
  assign obs = {state_o, ir_we, pc_we, pc_src, alu_op, alu_src, reg2loc,
                reg_we, mem_req, mem_we, mem_to_reg, instr_done};

  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [14:0] mk(input logic [2:0] st, input logic ir, input logic pw,
                                     input logic ps, input logic [1:0] ao, input logic as,
                                     input logic rl, input logic rw, input logic mr,
                                     input logic mw, input logic m2r, input logic dn);
    return {st, ir, pw, ps, ao, as, rl, rw, mr, mw, m2r, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input logic [14:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Drive one cycle's inputs, compare at the falling edge, then advance past the rising edge.
  task automatic cyc(input logic r, input logic [3:0] opc, input logic z, input logic rdy);
    logic [14:0] e;
    string       t;
    run = r; opcode = opc; alu_zero = z; mem_ready = rdy;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      e = obs;
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {17'd0, obs}, {17'd0, e});
    end
`ifdef MC_CTRL_PERF_EN
    check("cyc_cnt", cyc_cnt, exp_cyc);
    check("ret_cnt", ret_cnt, exp_ret);
    if (r || e[14:12] != 3'd0) exp_cyc++;
    if (e[0]) exp_ret++;
`endif
    @(posedge clk);
    #1;
  endtask

  logic [14:0] F1, FW, FI, D0, DN;
  logic [14:0] AE, AW, LE, LM, LW, BE1, BE0, SE, SMW, SMD;

  initial begin
    F1  = mk(3'd0, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    FW  = mk(3'd0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    FI  = 15'd0;
    D0  = mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    DN  = mk(3'd1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    AE  = mk(3'd2, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
    AW  = mk(3'd4, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 1);
    LE  = mk(3'd2, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0);
    LM  = mk(3'd3, 0, 0, 0, 2'b10, 1, 0, 0, 1, 0, 0, 0);
    LW  = mk(3'd4, 0, 0, 0, 2'b10, 1, 0, 1, 0, 0, 1, 1);
    BE1 = mk(3'd2, 0, 1, 1, 2'b01, 0, 1, 0, 0, 0, 0, 1);
    BE0 = mk(3'd2, 0, 0, 1, 2'b01, 0, 1, 0, 0, 0, 0, 1);
    SE  = mk(3'd2, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0);
    SMW = mk(3'd3, 0, 0, 0, 2'b00, 1, 1, 0, 1, 1, 0, 0);
    SMD = mk(3'd3, 0, 0, 0, 2'b00, 1, 1, 0, 1, 1, 0, 1);

    rst_n = 1'b0; run = 1'b1; opcode = 4'h0; alu_zero = 1'b0; mem_ready = 1'b1;
`ifdef MC_CTRL_PERF_EN
    exp_cyc = 0; exp_ret = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_outputs", {17'd0, obs}, 32'd0);
    rst_n = 1'b1;

    // ALU op, run dropped mid-instruction has no effect
    push("alu_fetch", F1); push("alu_decode", D0); push("alu_exec", AE); push("alu_wb", AW);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'b1000, 0, 1); cyc(0, 4'h0, 0, 1); cyc(0, 4'h0, 0, 1);

    // idle with run=0, stray mem_ready ignored; then run=1 waiting on memory
    push("idle0", FI); push("idle1", FI); push("idle2", FI); push("fetch_wait", FW);
    cyc(0, 4'h0, 0, 1); cyc(0, 4'h0, 0, 1); cyc(0, 4'h0, 0, 1); cyc(1, 4'h0, 0, 0);

    // LOAD with three wait cycles in MEM
    push("ld_fetch", F1); push("ld_decode", D0); push("ld_exec", LE);
    push("ld_mem_w0", LM); push("ld_mem_w1", LM); push("ld_mem_w2", LM); push("ld_mem_rdy", LM);
    push("ld_wb", LW);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'b1001, 0, 0); cyc(1, 4'h0, 0, 0);
    cyc(1, 4'h0, 0, 0); cyc(1, 4'h0, 0, 0); cyc(1, 4'h0, 0, 0); cyc(1, 4'h0, 0, 1);
    cyc(1, 4'h0, 0, 1);

    // branch taken / not taken
    push("br1_fetch", F1); push("br1_decode", D0); push("br1_exec", BE1);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'b0100, 0, 1); cyc(1, 4'h0, 1, 1);
    push("br0_fetch", F1); push("br0_decode", D0); push("br0_exec", BE0);
    cyc(1, 4'h0, 1, 1); cyc(1, 4'b0100, 1, 1); cyc(1, 4'h0, 0, 1);

    // STORE with one wait cycle, then NOP
    push("st_fetch", F1); push("st_decode", D0); push("st_exec", SE);
    push("st_mem_wait", SMW); push("st_mem_done", SMD);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'b0010, 0, 1); cyc(1, 4'h0, 0, 1);
    cyc(1, 4'h0, 0, 0); cyc(1, 4'h0, 0, 1);
    push("nop_fetch", F1); push("nop_decode", DN);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'h0, 0, 1);

    // two more ALU ops back to back
    for (int i = 0; i < 2; i++) begin
      push("alu2_fetch", F1); push("alu2_decode", D0); push("alu2_exec", AE); push("alu2_wb", AW);
      cyc(1, 4'h0, 0, 1); cyc(1, 4'b1000, 0, 1); cyc(1, 4'h0, 0, 1); cyc(1, 4'h0, 0, 1);
    end

    // reset while a LOAD is stalled in MEM
    push("rst_ld_fetch", F1); push("rst_ld_decode", D0); push("rst_ld_exec", LE);
    push("rst_ld_mem", LM);
    cyc(1, 4'h0, 0, 1); cyc(1, 4'b1001, 0, 0); cyc(1, 4'h0, 0, 0); cyc(1, 4'h0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_mem_outputs", {17'd0, obs}, 32'd0);
`ifdef MC_CTRL_PERF_EN
    check("reset_cyc_cnt", cyc_cnt, 32'd0);
    check("reset_ret_cnt", ret_cnt, 32'd0);
    exp_cyc = 0; exp_ret = 0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("post_rst_fetch_wait", FW); push("post_rst_idle", FI);
    push("post_rst_fetch", F1); push("post_rst_nop", DN);
    cyc(1, 4'h0, 0, 0); cyc(0, 4'h0, 0, 1); cyc(1, 4'h0, 0, 1); cyc(1, 4'h0, 0, 1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
